fm_dump_ctrl: RTL

Capture sequencer for the FM receiver's 8-bit dump buffer. It arbitrates between the IQ and demodulated-audio byte streams, decimates the selected stream and generates write address/enable into the byte-wide dump RAM. It also gates host readout and raises a one-cycle completion interrupt. It sits between the demodulator outputs and the dump RAM, driven by host commands decoded from the FM control register.

---
 rtl/fm_dump_ctrl_if.sv | 37 +++
 rtl/fm_dump_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fm_dump_ctrl_if.sv
// Capture/readout port bundle between the FM demodulator, host command decoder and dump RAM.
// The master side drives commands and sample streams; the slave side is the dump controller.
interface fm_dump_ctrl_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  cmd_valid;
  logic [3:0]            cmd;
  logic [3:0]            hw_state;
  logic [3:0]            decim;
  logic                  iq_valid;
  logic [7:0]            iq_data;
  logic                  audio_valid;
  logic [7:0]            audio_data;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_waddr;
  logic [7:0]            buf_wdata;
  logic                  rd_en;
  logic                  busy;
  logic                  src_sel;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  done_irq;
  logic                  abort_err;

  modport master (
    output cmd_valid, cmd, hw_state, decim,
    output iq_valid, iq_data, audio_valid, audio_data,
    input  buf_we, buf_waddr, buf_wdata,
    input  rd_en, busy, src_sel, fill_count, done_irq, abort_err
  );

  modport slave (
    input  cmd_valid, cmd, hw_state, decim,
    input  iq_valid, iq_data, audio_valid, audio_data,
    output buf_we, buf_waddr, buf_wdata,
    output rd_en, busy, src_sel, fill_count, done_irq, abort_err
  );
endinterface

// File: rtl/fm_dump_ctrl.sv
// Dump buffer capture sequencer: selects the IQ or audio stream, decimates it and writes it
// linearly from BASE_ADDR to TOP_ADDR, then gates host readout until the buffer is released.
module fm_dump_ctrl #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 13'h100,
  parameter logic [ADDR_WIDTH-1:0] TOP_ADDR   = 13'h1FFF
) (
  input  logic           clk,
  input  logic           RST,
  fm_dump_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    READ    = 2'd3
  } state_t;

  localparam logic [3:0]            CMD_START_IQ    = 4'h1;
  localparam logic [3:0]            CMD_START_AUDIO = 4'h2;
  localparam logic [3:0]            CMD_READ        = 4'h4;
  localparam logic [3:0]            CMD_RELEASE     = 4'h8;
  localparam logic [3:0]            CMD_ABORT       = 4'hF;
  localparam logic [3:0]            HW_RCEV         = 4'b0010;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE        = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FILL_ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  buf_we_r;
  logic [ADDR_WIDTH-1:0] buf_waddr_r;
  logic [7:0]            buf_wdata_r;
  logic [ADDR_WIDTH-1:0] next_addr_r;
  logic [ADDR_WIDTH:0]   fill_r;
  logic [3:0]            decim_r;
  logic [3:0]            cnt_r;
  logic                  src_sel_r;
  logic                  rd_en_r;
  logic                  busy_r;
  logic                  done_irq_r;
  logic                  abort_err_r;

  logic                  start_iq_s;
  logic                  start_audio_s;
  logic                  read_s;
  logic                  release_s;
  logic                  abort_s;
  logic                  rcev_s;
  logic                  sel_valid_s;
  logic [7:0]            sel_data_s;
  logic                  wr_s;
  logic                  cnt_dec_s;
  logic                  start_s;
  logic                  lost_rcev_s;

  assign start_iq_s    = bus.cmd_valid && (bus.cmd == CMD_START_IQ);
  assign start_audio_s = bus.cmd_valid && (bus.cmd == CMD_START_AUDIO);
  assign read_s        = bus.cmd_valid && (bus.cmd == CMD_READ);
  assign release_s     = bus.cmd_valid && (bus.cmd == CMD_RELEASE);
  assign abort_s       = bus.cmd_valid && (bus.cmd == CMD_ABORT);
  assign rcev_s        = (bus.hw_state == HW_RCEV);
  assign sel_valid_s   = src_sel_r ? bus.audio_valid : bus.iq_valid;
  assign sel_data_s    = src_sel_r ? bus.audio_data  : bus.iq_data;

  // Next-state and per-cycle capture decisions; ABORT overrides everything, including a write.
  always_comb begin
    state_nxt_s = state_r;
    wr_s        = 1'b0;
    cnt_dec_s   = 1'b0;
    start_s     = 1'b0;
    lost_rcev_s = 1'b0;
    if (abort_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if ((start_iq_s || start_audio_s) && rcev_s) begin
            state_nxt_s = CAPTURE;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CAPTURE: begin
          if (!rcev_s) begin
            state_nxt_s = IDLE;
            lost_rcev_s = 1'b1;
          end else if (sel_valid_s && (cnt_r == 4'd0)) begin
            wr_s = 1'b1;
            if (next_addr_r == TOP_ADDR) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = CAPTURE;
            end
          end else if (sel_valid_s) begin
            cnt_dec_s = 1'b1;
          end else begin
            state_nxt_s = CAPTURE;
          end
        end
        DONE: begin
          if (read_s) begin
            state_nxt_s = READ;
          end else begin
            state_nxt_s = DONE;
          end
        end
        READ: begin
          if (release_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = READ;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered write path, capture bookkeeping and status outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      buf_we_r    <= 1'b0;
      buf_waddr_r <= BASE_ADDR;
      buf_wdata_r <= 8'h00;
      next_addr_r <= BASE_ADDR;
      fill_r      <= {(ADDR_WIDTH+1){1'b0}};
      decim_r     <= 4'd0;
      cnt_r       <= 4'd0;
      src_sel_r   <= 1'b0;
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_irq_r  <= 1'b0;
      abort_err_r <= 1'b0;
    end else begin
      buf_we_r   <= wr_s;
      busy_r     <= (state_nxt_s == CAPTURE);
      rd_en_r    <= (state_nxt_s == READ);
      // The final write sits at TOP_ADDR, so its enable cycle flags completion one cycle later.
      done_irq_r <= buf_we_r && (buf_waddr_r == TOP_ADDR);
      if (start_s) begin
        src_sel_r   <= start_audio_s;
        decim_r     <= bus.decim;
        next_addr_r <= BASE_ADDR;
        buf_waddr_r <= BASE_ADDR;
        fill_r      <= {(ADDR_WIDTH+1){1'b0}};
        cnt_r       <= 4'd0;
        abort_err_r <= 1'b0;
      end else if (wr_s) begin
        buf_waddr_r <= next_addr_r;
        buf_wdata_r <= sel_data_s;
        next_addr_r <= next_addr_r + ADDR_ONE;
        fill_r      <= fill_r + FILL_ONE;
        cnt_r       <= decim_r;
      end else if (cnt_dec_s) begin
        cnt_r <= cnt_r - 4'd1;
      end else if (lost_rcev_s) begin
        abort_err_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.buf_we     = buf_we_r;
  assign bus.buf_waddr  = buf_waddr_r;
  assign bus.buf_wdata  = buf_wdata_r;
  assign bus.rd_en      = rd_en_r;
  assign bus.busy       = busy_r;
  assign bus.src_sel    = src_sel_r;
  assign bus.fill_count = fill_r;
  assign bus.done_irq   = done_irq_r;
  assign bus.abort_err  = abort_err_r;

endmodule
